// File: rtl/snoop_bus_controller.sv
// snoop_bus_controller: bus-side MSI snooping controller for an N-line,
// fully associative private cache. Owns the per-line state/tag arrays,
// takes one snooped transaction at a time, and requests write-backs.
//
// Handshakes:
//   bus:  a transaction transfers on a rising edge where bus_valid && bus_ready;
//         bus_ready is high only while the FSM is IDLE.
//   wb:   write_back/abort_mem/wb_index are held until wb_ack is sampled high
//         in WRITEBACK; wb_ack at any other time is ignored.
//
// Optional build macro: SNOOP_STATS_EN adds stat_hits / stat_wbacks counters.
module snoop_bus_controller #(
  parameter int NUM_LINES = 4,
  parameter int TAG_W     = 8,
  localparam int IW       = $clog2(NUM_LINES)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             bus_valid,
  output logic             bus_ready,
  input  logic [1:0]       bus_op,
  input  logic [TAG_W-1:0] bus_tag,
  input  logic             cpu_wr_en,
  input  logic [IW-1:0]    cpu_wr_index,
  input  logic [1:0]       cpu_wr_state,
  input  logic [TAG_W-1:0] cpu_wr_tag,
  output logic             write_back,
  output logic             abort_mem,
  output logic [IW-1:0]    wb_index,
  input  logic             wb_ack,
  output logic             snoop_done,
  output logic             snoop_hit,
  input  logic [IW-1:0]    dbg_index,
  output logic [1:0]       dbg_state,
`ifdef SNOOP_STATS_EN
  output logic [15:0]      stat_hits,
  output logic [15:0]      stat_wbacks,
`endif
  output logic [1:0]       dbg_fsm
);

  localparam logic [1:0] OP_RM  = 2'b00;
  localparam logic [1:0] OP_WM  = 2'b01;
  localparam logic [1:0] OP_INV = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  localparam logic [1:0] ST_I = 2'b00;
  localparam logic [1:0] ST_E = 2'b01;
  localparam logic [1:0] ST_S = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_WB, S_DONE} fsm_t;

  fsm_t             fsm_q, fsm_d;
  logic [1:0]       op_q;
  logic [TAG_W-1:0] tag_q;
  logic             hit_q;
  logic [IW-1:0]    idx_q;

  logic [1:0]       line_state [NUM_LINES];
  logic [TAG_W-1:0] line_tag   [NUM_LINES];

  logic             lk_hit;
  logic [IW-1:0]    lk_idx;
  logic             lk_wb;

  // MSI transition of a hit line for a given snooped op
  function automatic logic [1:0] next_line(input logic [1:0] op, input logic [1:0] cur);
    next_line = cur;
    case (cur)
      ST_E: begin
        if (op == OP_RM)      next_line = ST_S;
        else if (op == OP_WM) next_line = ST_I;
      end
      ST_S: begin
        if (op == OP_WM || op == OP_INV) next_line = ST_I;
      end
      default: next_line = cur;
    endcase
  endfunction

  // Associative match of the latched tag; descending scan so the lowest index wins
  always_comb begin
    lk_hit = 1'b0;
    lk_idx = '0;
    for (int i = NUM_LINES - 1; i >= 0; i--) begin
      if (line_state[i] != ST_I && line_tag[i] == tag_q) begin
        lk_hit = 1'b1;
        lk_idx = IW'(i);
      end
    end
    // Reserved op behaves as a miss
    if (op_q == OP_RSV) lk_hit = 1'b0;
    lk_wb = lk_hit && (line_state[lk_idx] == ST_E) && (op_q == OP_RM || op_q == OP_WM);
  end

  // Next-state logic
  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      S_IDLE:   if (bus_valid) fsm_d = S_LOOKUP;
      S_LOOKUP: fsm_d = lk_wb ? S_WB : S_DONE;
      S_WB:     if (wb_ack) fsm_d = S_DONE;
      S_DONE:   fsm_d = S_IDLE;
      default:  fsm_d = S_IDLE;
    endcase
  end

  // FSM register and per-transaction latches
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fsm_q <= S_IDLE;
      op_q  <= 2'b00;
      tag_q <= '0;
      hit_q <= 1'b0;
      idx_q <= '0;
    end else begin
      fsm_q <= fsm_d;
      if (fsm_q == S_IDLE && bus_valid) begin
        op_q  <= bus_op;
        tag_q <= bus_tag;
      end
      if (fsm_q == S_LOOKUP) begin
        hit_q <= lk_hit;
        idx_q <= lk_idx;
      end
    end
  end

  // Line arrays: CPU installs only in IDLE; snoop updates at LOOKUP or at the wb_ack edge
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_LINES; i++) begin
        line_state[i] <= ST_I;
        line_tag[i]   <= '0;
      end
    end else begin
      if (fsm_q == S_IDLE && cpu_wr_en) begin
        line_state[cpu_wr_index] <= (cpu_wr_state == 2'b11) ? ST_I : cpu_wr_state;
        line_tag[cpu_wr_index]   <= cpu_wr_tag;
      end
      if (fsm_q == S_LOOKUP && lk_hit && !lk_wb)
        line_state[lk_idx] <= next_line(op_q, line_state[lk_idx]);
      if (fsm_q == S_WB && wb_ack)
        line_state[idx_q] <= next_line(op_q, line_state[idx_q]);
    end
  end

`ifdef SNOOP_STATS_EN
  // Saturating hit and write-back counters
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stat_hits   <= 16'h0000;
      stat_wbacks <= 16'h0000;
    end else begin
      if (fsm_q == S_DONE && hit_q && stat_hits != 16'hFFFF)
        stat_hits <= stat_hits + 16'h0001;
      if (fsm_q == S_WB && wb_ack && stat_wbacks != 16'hFFFF)
        stat_wbacks <= stat_wbacks + 16'h0001;
    end
  end
`endif

  assign bus_ready  = (fsm_q == S_IDLE);
  assign write_back = (fsm_q == S_WB);
  assign abort_mem  = (fsm_q == S_WB);
  assign wb_index   = (fsm_q == S_WB) ? idx_q : '0;
  assign snoop_done = (fsm_q == S_DONE);
  assign snoop_hit  = (fsm_q == S_DONE) && hit_q;
  assign dbg_state  = line_state[dbg_index];
  assign dbg_fsm    = fsm_q;

endmodule

// File: tb/tb_snoop_bus_controller.sv
// tb_snoop_bus_controller: directed vector table plus hand-written sequences
// for delayed wb_ack, same-cycle install+snoop, blocked CPU writes and reset
// during write-back.
module tb_snoop_bus_controller;

  logic       clock, reset;
  logic       bus_valid, bus_ready;
  logic [1:0] bus_op;
  logic [7:0] bus_tag;
  logic       cpu_wr_en;
  logic [1:0] cpu_wr_index, cpu_wr_state;
  logic [7:0] cpu_wr_tag;
  logic       write_back, abort_mem, wb_ack, snoop_done, snoop_hit;
  logic [1:0] wb_index, dbg_index, dbg_state, dbg_fsm;
`ifdef SNOOP_STATS_EN
  logic [15:0] stat_hits, stat_wbacks;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  snoop_bus_controller #(.NUM_LINES(4), .TAG_W(8)) dut (
    .clock(clock), .reset(reset),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_op(bus_op), .bus_tag(bus_tag),
    .cpu_wr_en(cpu_wr_en), .cpu_wr_index(cpu_wr_index), .cpu_wr_state(cpu_wr_state),
    .cpu_wr_tag(cpu_wr_tag),
    .write_back(write_back), .abort_mem(abort_mem), .wb_index(wb_index), .wb_ack(wb_ack),
    .snoop_done(snoop_done), .snoop_hit(snoop_hit),
    .dbg_index(dbg_index), .dbg_state(dbg_state),
`ifdef SNOOP_STATS_EN
    .stat_hits(stat_hits), .stat_wbacks(stat_wbacks),
`endif
    .dbg_fsm(dbg_fsm)
  );

  // Clock
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic       inst_en;
    logic [1:0] inst_idx;
    logic [1:0] inst_st;
    logic [7:0] inst_tag;
    logic [1:0] op;
    logic [7:0] tag;
    logic       exp_wb;
    logic [1:0] exp_wbi;
    logic       exp_hit;
    logic [1:0] chk_idx;
    logic [1:0] exp_st;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic line_chk(input string name, input logic [1:0] idx, input logic [1:0] exp);
    dbg_index = idx;
    #1;
    chk(name, {30'd0, dbg_state}, {30'd0, exp});
  endtask

  // One table record: optional install cycle, then a snoop checked cycle by cycle
  task automatic run_vec(input int n, input vec_t v);
    if (v.inst_en) begin
      cpu_wr_en = 1'b1; cpu_wr_index = v.inst_idx;
      cpu_wr_state = v.inst_st; cpu_wr_tag = v.inst_tag;
      step();
      cpu_wr_en = 1'b0;
    end
    chk($sformatf("v%0d idle_ready", n), {31'd0, bus_ready}, 32'd1);
    bus_valid = 1'b1; bus_op = v.op; bus_tag = v.tag;
    step();
    bus_valid = 1'b0;
    chk($sformatf("v%0d lookup_ready", n), {31'd0, bus_ready}, 32'd0);
    chk($sformatf("v%0d lookup_done", n), {31'd0, snoop_done}, 32'd0);
    step();
    if (v.exp_wb) begin
      chk($sformatf("v%0d write_back", n), {31'd0, write_back}, 32'd1);
      chk($sformatf("v%0d abort_mem", n), {31'd0, abort_mem}, 32'd1);
      chk($sformatf("v%0d wb_index", n), {30'd0, wb_index}, {30'd0, v.exp_wbi});
      chk($sformatf("v%0d wb_done_early", n), {31'd0, snoop_done}, 32'd0);
      wb_ack = 1'b1;
      step();
      wb_ack = 1'b0;
    end else begin
      chk($sformatf("v%0d no_write_back", n), {31'd0, write_back}, 32'd0);
    end
    chk($sformatf("v%0d snoop_done", n), {31'd0, snoop_done}, 32'd1);
    chk($sformatf("v%0d snoop_hit", n), {31'd0, snoop_hit}, {31'd0, v.exp_hit});
    line_chk($sformatf("v%0d line_state", n), v.chk_idx, v.exp_st);
    step();
  endtask

  initial begin
    //          inst idx  st     tag    op     tag    wb  wbi  hit idx st
    vecs[0] = '{1'b1, 2'd2, 2'b01, 8'h5A, 2'b00, 8'h5A, 1'b1, 2'd2, 1'b1, 2'd2, 2'b10};
    vecs[1] = '{1'b1, 2'd1, 2'b10, 8'h33, 2'b10, 8'h33, 1'b0, 2'd0, 1'b1, 2'd1, 2'b00};
    vecs[2] = '{1'b0, 2'd0, 2'b00, 8'h00, 2'b10, 8'h33, 1'b0, 2'd0, 1'b0, 2'd1, 2'b00};
    vecs[3] = '{1'b0, 2'd0, 2'b00, 8'h00, 2'b00, 8'h5A, 1'b0, 2'd0, 1'b1, 2'd2, 2'b10};
    vecs[4] = '{1'b0, 2'd0, 2'b00, 8'h00, 2'b01, 8'h5A, 1'b0, 2'd0, 1'b1, 2'd2, 2'b00};
    vecs[5] = '{1'b1, 2'd0, 2'b01, 8'hAA, 2'b11, 8'hAA, 1'b0, 2'd0, 1'b0, 2'd0, 2'b01};
    vecs[6] = '{1'b0, 2'd0, 2'b00, 8'h00, 2'b10, 8'hAA, 1'b0, 2'd0, 1'b1, 2'd0, 2'b01};
    vecs[7] = '{1'b1, 2'd3, 2'b10, 8'hAA, 2'b00, 8'hAA, 1'b1, 2'd0, 1'b1, 2'd0, 2'b10};
    vecs[8] = '{1'b1, 2'd1, 2'b11, 8'hC3, 2'b00, 8'hC3, 1'b0, 2'd0, 1'b0, 2'd1, 2'b00};

    reset = 1'b1; bus_valid = 1'b0; bus_op = 2'b00; bus_tag = 8'h00;
    cpu_wr_en = 1'b0; cpu_wr_index = 2'd0; cpu_wr_state = 2'b00; cpu_wr_tag = 8'h00;
    wb_ack = 1'b0; dbg_index = 2'd0;
    step();
    step();
    reset = 1'b0;

    // Reset state
    chk("rst bus_ready", {31'd0, bus_ready}, 32'd1);
    chk("rst write_back", {31'd0, write_back}, 32'd0);
    chk("rst abort_mem", {31'd0, abort_mem}, 32'd0);
    chk("rst wb_index", {30'd0, wb_index}, 32'd0);
    chk("rst snoop_done", {31'd0, snoop_done}, 32'd0);
    chk("rst snoop_hit", {31'd0, snoop_hit}, 32'd0);
    for (int i = 0; i < 4; i++) line_chk($sformatf("rst line%0d", i), 2'(i), 2'b00);

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // Delayed wb_ack: write_back held 5 cycles, line changes only after ack
    cpu_wr_en = 1'b1; cpu_wr_index = 2'd0; cpu_wr_state = 2'b01; cpu_wr_tag = 8'h77;
    step();
    cpu_wr_en = 1'b0;
    bus_valid = 1'b1; bus_op = 2'b01; bus_tag = 8'h77;
    step();
    bus_valid = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("dly%0d write_back", i), {31'd0, write_back}, 32'd1);
      chk($sformatf("dly%0d bus_ready", i), {31'd0, bus_ready}, 32'd0);
      line_chk($sformatf("dly%0d line0", i), 2'd0, 2'b01);
      step();
    end
    chk("dly wb_index", {30'd0, wb_index}, 32'd0);
    chk("dly write_back_at_ack", {31'd0, write_back}, 32'd1);
    wb_ack = 1'b1;
    step();
    wb_ack = 1'b0;
    chk("dly snoop_done", {31'd0, snoop_done}, 32'd1);
    chk("dly snoop_hit", {31'd0, snoop_hit}, 32'd1);
    line_chk("dly line0", 2'd0, 2'b00);
    step();

    // Same-cycle install + snoop; a CPU write during LOOKUP must be ignored
    cpu_wr_en = 1'b1; cpu_wr_index = 2'd3; cpu_wr_state = 2'b10; cpu_wr_tag = 8'h10;
    bus_valid = 1'b1; bus_op = 2'b01; bus_tag = 8'h10;
    step();
    bus_valid = 1'b0;
    cpu_wr_index = 2'd2; cpu_wr_state = 2'b01; cpu_wr_tag = 8'h99;
    step();
    cpu_wr_en = 1'b0;
    chk("same snoop_done", {31'd0, snoop_done}, 32'd1);
    chk("same snoop_hit", {31'd0, snoop_hit}, 32'd1);
    chk("same no_write_back", {31'd0, write_back}, 32'd0);
    line_chk("same line3", 2'd3, 2'b00);
    line_chk("busy cpu_wr ignored", 2'd2, 2'b00);
    step();

`ifdef SNOOP_STATS_EN
    chk("stat_hits", {16'd0, stat_hits}, 32'd8);
    chk("stat_wbacks", {16'd0, stat_wbacks}, 32'd3);
`endif

    // Reset asserted during WRITEBACK
    cpu_wr_en = 1'b1; cpu_wr_index = 2'd1; cpu_wr_state = 2'b01; cpu_wr_tag = 8'h44;
    step();
    cpu_wr_en = 1'b0;
    bus_valid = 1'b1; bus_op = 2'b00; bus_tag = 8'h44;
    step();
    bus_valid = 1'b0;
    step();
    chk("mid write_back", {31'd0, write_back}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst bus_ready", {31'd0, bus_ready}, 32'd1);
    chk("mid_rst write_back", {31'd0, write_back}, 32'd0);
    chk("mid_rst abort_mem", {31'd0, abort_mem}, 32'd0);
    chk("mid_rst wb_index", {30'd0, wb_index}, 32'd0);
    chk("mid_rst snoop_done", {31'd0, snoop_done}, 32'd0);
    chk("mid_rst snoop_hit", {31'd0, snoop_hit}, 32'd0);
    for (int i = 0; i < 4; i++) line_chk($sformatf("mid_rst line%0d", i), 2'(i), 2'b00);
`ifdef SNOOP_STATS_EN
    chk("mid_rst stat_hits", {16'd0, stat_hits}, 32'd0);
    chk("mid_rst stat_wbacks", {16'd0, stat_wbacks}, 32'd0);
`endif
    step();
    reset = 1'b0;
    step();
    chk("post_rst bus_ready", {31'd0, bus_ready}, 32'd1);
    chk("post_rst snoop_done", {31'd0, snoop_done}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
